pipeline_hazard_controller: RTL
===============================

Name: pipeline_hazard_controller

Overview:
- Central stall/flush sequencer for the 5-stage pipeline registers (IF/ID "fd", ID/EX "de", EX/MEM "em", MEM/WB "mw").
- Detects load-use hazards and resolves taken-branch redirects. The redirect arrives registered at the EX/MEM stage.
- Runs a handshake FSM that freezes the pipeline while a variable-latency data memory completes a load/store.
- Keeps saturating stall/flush performance counters and a sticky memory-timeout error.

Parameters:
- CNT_W, 32, width of performance counters.
- TIMEOUT, 64, max cycles in MEM_WAIT before error (must be >=2).
- TO_W, 7, width of timeout counter (must hold TIMEOUT).

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous reset, active-low
- fd_rs1_addr_i  in  5  rs1 of instruction in ID
- fd_rs2_addr_i  in  5  rs2 of instruction in ID
- fd_rs1_used_i  in  1  ID instruction reads rs1
- fd_rs2_used_i  in  1  ID instruction reads rs2
- de_mem_read_i  in  1  instruction in EX is a load
- de_rd_addr_i  in  5  destination of instruction in EX
- em_mem_read_i  in  1  EX/MEM holds a load
- em_mem_write_i  in  1  EX/MEM holds a store
- em_pc_select_i  in  1  EX/MEM holds a taken branch/jump
- dmem_ready_i  in  1  data memory completes access this cycle
- dmem_req_o  out  1  data memory request
- pc_stall_o  out  1  hold PC
- fd_stall_o, de_stall_o, em_stall_o  out  1 each  hold register
- fd_flush_o, de_flush_o, em_flush_o, mw_flush_o  out  1 each  load bubble (all controls 0)
- stall_cycles_o  out  CNT_W  cycles with pc_stall_o=1
- flush_events_o  out  CNT_W  count of branch flushes
- dmem_timeout_o  out  1  sticky error

Behaviour:
- Reset (reset_i==0 at posedge):
  - FSM goes to IDLE; counters, timeout counter and dmem_timeout_o clear to 0.
  - While reset_i==0, outputs are forced: all flush=1, all stall=0, dmem_req_o=0.
- FSM states are IDLE, MEM_WAIT and ERROR. All stall/flush outputs are combinational from state and inputs (0-cycle latency).
- mem_op = em_mem_read_i | em_mem_write_i.
- IDLE:
  - dmem_req_o = mem_op.
  - If mem_op && !dmem_ready_i: go to MEM_WAIT, clear the timeout counter, and apply mem_stall this cycle.
  - If mem_op && dmem_ready_i: single-cycle access, no stall.
- mem_stall:
  - pc/fd/de/em stall=1 and mw_flush=1.
  - All other flushes are 0. A pending branch flush or load-use is deferred; its inputs stay held by the stalled registers.
- MEM_WAIT:
  - dmem_req_o=1 and the timeout counter increments.
  - If dmem_ready_i: return to IDLE. Stalls deassert in this same cycle so the em/mw advance captures the data; normal hazard logic applies.
  - Else if counter==TIMEOUT-1: go to ERROR.
  - Else apply mem_stall.
- ERROR:
  - dmem_timeout_o=1 (sticky) and mem_stall is held permanently; dmem_req_o=0.
  - Exit only via reset.
- Branch flush (IDLE without mem_stall, em_pc_select_i=1):
  - fd_flush=de_flush=em_flush=1, no stalls.
  - flush_events_o increments by 1.
- Load-use (IDLE without mem_stall, no branch):
  - Condition: de_mem_read_i && de_rd_addr_i!=0 && ((fd_rs1_used_i && rs1==rd) || (fd_rs2_used_i && rs2==rd)).
  - Response: pc_stall=fd_stall=1, de_flush=1, exactly one cycle per occurrence (the bubble clears the condition).
- Priority is mem_stall > branch flush > load-use. A branch coincident with load-use discards the load-use stall.
- stall_cycles_o increments on every non-reset cycle with pc_stall_o=1.
- Both counters saturate at 2^CNT_W-1 (no wrap).
- A stall output and a flush output for the same register are never both 1.

Decomposition:
- Shared package pipeline_ctrl_pkg:
  - FSM state typedef (2-bit: IDLE=0, MEM_WAIT=1, ERROR=2).
  - Register-index constant X0=5'd0.
  - Bubble-control defaults.
- One sub-module: sat_counter (parameter W; inputs inc and clear; saturating output), instantiated twice.

Test Plan:
- Load-use: de_mem_read=1, rd=5, fd_rs1=5, rs1_used=1 → pc_stall=fd_stall=de_flush=1 for exactly 1 cycle; stall_cycles_o=1. Same with rd=0 → no stall.
- Branch: em_pc_select=1 for 1 cycle, with a concurrent load-use condition → fd/de/em_flush=1, no stalls, flush_events_o=1.
- Memory wait: em_mem_read=1, dmem_ready low for 3 cycles then high → dmem_req_o=1 for 4 cycles; stalls and mw_flush=1 for 3 cycles; release in the ready cycle; stall_cycles_o=3.
- Deferred branch: em_pc_select=1 while a store waits 2 cycles → no flush during the wait; flush asserts in the ready cycle.
- Timeout: TIMEOUT=4, dmem_ready held 0 → ERROR after 4 wait cycles; dmem_timeout_o=1 sticky; stalls held; reset_i=0 clears everything to the IDLE/flush-forced values.
- Saturation: CNT_W=3, 10 load-use stalls → stall_cycles_o=7.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   state_e    : sequencer states (IDLE, MEM_WAIT, ERROR)
//   X0         : hardwired-zero register index, never a real hazard source
//   ctrl_t     : bundle of memory request plus per-register stall/flush controls
//   CTRL_NONE  : pipeline flows freely, no request
//   CTRL_RESET : every register loads a bubble, nothing held, no request
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_e;

    localparam logic [4:0] X0 = 5'd0;

    typedef struct packed {
        logic dmem_req;
        logic pc_stall;
        logic fd_stall;
        logic de_stall;
        logic em_stall;
        logic fd_flush;
        logic de_flush;
        logic em_flush;
        logic mw_flush;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE  = 9'b0_0000_0000;
    localparam ctrl_t CTRL_RESET = 9'b0_0000_1111;

endpackage

// File: rtl/pipeline_hazard_controller_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   i_clk   : clock
//   i_inc   : add one this cycle (ignored once all ones)
//   i_clear : synchronous clear, has priority over i_inc
//   o_count : current count, sticks at 2^W-1
module sat_counter #(
    parameter int W = 32
) (
    input  logic         i_clk,
    input  logic         i_inc,
    input  logic         i_clear,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_clear) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Central stall/flush sequencer for the IF/ID (fd), ID/EX (de), EX/MEM (em)
// and MEM/WB (mw) pipeline registers.
//   clk_i, reset_i         : clock, synchronous active-low reset
//   fd_rs*_addr_i/used_i   : source registers read by the instruction in ID
//   de_mem_read_i, de_rd_addr_i : load in EX and its destination
//   em_mem_read_i/write_i  : memory access held in EX/MEM
//   em_pc_select_i         : taken branch/jump held in EX/MEM
//   dmem_ready_i, dmem_req_o : data memory handshake
//   pc/fd/de/em_stall_o    : hold PC / pipeline register
//   fd/de/em/mw_flush_o    : load a bubble into pipeline register
//   stall_cycles_o, flush_events_o : saturating performance counters
//   dmem_timeout_o         : sticky memory-timeout error
module pipeline_hazard_controller
    import pipeline_ctrl_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 64,
    parameter int TO_W    = 7
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [4:0]       fd_rs1_addr_i,
    input  logic [4:0]       fd_rs2_addr_i,
    input  logic             fd_rs1_used_i,
    input  logic             fd_rs2_used_i,
    input  logic             de_mem_read_i,
    input  logic [4:0]       de_rd_addr_i,
    input  logic             em_mem_read_i,
    input  logic             em_mem_write_i,
    input  logic             em_pc_select_i,
    input  logic             dmem_ready_i,
    output logic             dmem_req_o,
    output logic             pc_stall_o,
    output logic             fd_stall_o,
    output logic             de_stall_o,
    output logic             em_stall_o,
    output logic             fd_flush_o,
    output logic             de_flush_o,
    output logic             em_flush_o,
    output logic             mw_flush_o,
    output logic [CNT_W-1:0] stall_cycles_o,
    output logic [CNT_W-1:0] flush_events_o,
    output logic             dmem_timeout_o
);

    localparam logic [TO_W-1:0] LP_TO_LAST = TO_W'(TIMEOUT - 1);

    state_e          r_state;
    state_e          w_state_nxt;
    logic [TO_W-1:0] r_to_cnt;
    logic [TO_W-1:0] w_to_cnt_nxt;
    logic            r_timeout;
    ctrl_t           w_ctrl;
    logic            w_mem_op;
    logic            w_mem_stall;
    logic            w_load_use;
    logic            w_branch;

    assign w_mem_op = em_mem_read_i | em_mem_write_i;

    // x0 is never written, so a load targeting it cannot create a hazard.
    assign w_load_use = de_mem_read_i && (de_rd_addr_i != X0) &&
                        ((fd_rs1_used_i && (fd_rs1_addr_i == de_rd_addr_i)) ||
                         (fd_rs2_used_i && (fd_rs2_addr_i == de_rd_addr_i)));

    always_comb begin
        w_state_nxt  = r_state;
        w_to_cnt_nxt = r_to_cnt;
        w_mem_stall  = 1'b0;
        w_branch     = 1'b0;
        w_ctrl       = CTRL_NONE;

        unique case (r_state)
            IDLE: begin
                w_ctrl.dmem_req = w_mem_op;
                if (w_mem_op && !dmem_ready_i) begin
                    w_state_nxt  = MEM_WAIT;
                    w_to_cnt_nxt = '0;
                    w_mem_stall  = 1'b1;
                end
            end
            MEM_WAIT: begin
                w_ctrl.dmem_req = 1'b1;
                w_to_cnt_nxt    = r_to_cnt + 1'b1;
                if (dmem_ready_i) begin
                    // Release in the ready cycle so em/mw capture the data now.
                    w_state_nxt = IDLE;
                end else begin
                    // Keep holding through the final wait cycle; ERROR holds on.
                    w_mem_stall = 1'b1;
                    if (r_to_cnt == LP_TO_LAST) begin
                        w_state_nxt = ERROR;
                    end
                end
            end
            ERROR: begin
                w_mem_stall = 1'b1;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // Deferred hazards keep their inputs in the frozen registers.
        if (w_mem_stall) begin
            w_ctrl.pc_stall = 1'b1;
            w_ctrl.fd_stall = 1'b1;
            w_ctrl.de_stall = 1'b1;
            w_ctrl.em_stall = 1'b1;
            w_ctrl.mw_flush = 1'b1;
        end else if (em_pc_select_i) begin
            w_branch        = 1'b1;
            w_ctrl.fd_flush = 1'b1;
            w_ctrl.de_flush = 1'b1;
            w_ctrl.em_flush = 1'b1;
        end else if (w_load_use) begin
            w_ctrl.pc_stall = 1'b1;
            w_ctrl.fd_stall = 1'b1;
            w_ctrl.de_flush = 1'b1;
        end

        if (!reset_i) begin
            w_ctrl   = CTRL_RESET;
            w_branch = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            r_state   <= IDLE;
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_to_cnt <= w_to_cnt_nxt;
            if (w_state_nxt == ERROR) begin
                r_timeout <= 1'b1;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .i_clk   (clk_i),
        .i_inc   (w_ctrl.pc_stall),
        .i_clear (!reset_i),
        .o_count (stall_cycles_o)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .i_clk   (clk_i),
        .i_inc   (w_branch),
        .i_clear (!reset_i),
        .o_count (flush_events_o)
    );

    assign dmem_req_o     = w_ctrl.dmem_req;
    assign pc_stall_o     = w_ctrl.pc_stall;
    assign fd_stall_o     = w_ctrl.fd_stall;
    assign de_stall_o     = w_ctrl.de_stall;
    assign em_stall_o     = w_ctrl.em_stall;
    assign fd_flush_o     = w_ctrl.fd_flush;
    assign de_flush_o     = w_ctrl.de_flush;
    assign em_flush_o     = w_ctrl.em_flush;
    assign mw_flush_o     = w_ctrl.mw_flush;
    assign dmem_timeout_o = r_timeout;

endmodule
